// File: rtl/sp_ram_be_if.sv
// ============================================================================
// Module      : sp_ram_be_if
// Description : Request/response bundle for the byte-enabled single-port RAM.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sp_ram_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  busy;

    modport master (
        output en, we, be, addr, din,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  en, we, be, addr, din,
        output dout, dout_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/sp_ram_be.sv
// ============================================================================
// Module      : sp_ram_be
// Description : Single-port sync RAM with byte enables, selectable
//               read-during-write mode, optional output register and
//               post-reset array clear.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_ram_be #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sp_ram_be_if.slave  bus
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    logic                  w_acc;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic                  w_clr_we;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_acc      = (r_state == ST_READY) && bus.en;
    assign w_in_range = ({1'b0, bus.addr} < C_DEPTH);
    assign w_wr_en    = w_acc && bus.we && w_in_range && !rst;
    assign w_clr_we   = (r_state == ST_CLEAR) && !rst;
    assign w_old      = w_in_range ? r_mem[bus.addr] : '0;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane
            assign w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.be[i]
                ? bus.din[i*BYTE_WIDTH +: BYTE_WIDTH]
                : w_old[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // Clear sequencer: one word per cycle, busy drops on the edge that writes the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_busy  <= (CLEAR_ON_RESET != 0);
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
                r_state <= ST_READY;
                r_busy  <= 1'b0;
            end
        end
    end

    // Array storage carries no reset; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.addr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= 1'b0;
            if (w_acc) begin
                if (!bus.we) begin
                    r_s1_data  <= w_old;
                    r_s1_valid <= 1'b1;
                end else if (RDW_MODE == 0) begin
                    r_s1_data  <= w_old;
                    r_s1_valid <= 1'b1;
                end else if (RDW_MODE == 1) begin
                    r_s1_data  <= w_in_range ? w_merged : '0;
                    r_s1_valid <= 1'b1;
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_dout_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_dout <= r_s1_data;
                    end
                end
            end

            assign bus.dout       = r_dout;
            assign bus.dout_valid = r_dout_valid;
        end else begin : g_no_out_reg
            assign bus.dout       = r_s1_data;
            assign bus.dout_valid = r_s1_valid;
        end
    endgenerate

    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sp_ram_be.sv
// ============================================================================
// Module      : tb_sp_ram_be
// Description : Directed self-checking bench; five RAM configurations share one bus.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sp_ram_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        rst_b;
    logic        r_en;
    logic        r_we;
    logic [3:0]  r_be;
    logic [3:0]  r_addr;
    logic [31:0] r_din;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // if0: READ_FIRST, if1: WRITE_FIRST, if2: NO_CHANGE, if3: OUT_REG, if4: DEPTH 12
    sp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if0 ();
    sp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if1 ();
    sp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if2 ();
    sp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if3 ();
    sp_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if4 ();

    assign if0.en = r_en; assign if0.we = r_we; assign if0.be = r_be; assign if0.addr = r_addr; assign if0.din = r_din;
    assign if1.en = r_en; assign if1.we = r_we; assign if1.be = r_be; assign if1.addr = r_addr; assign if1.din = r_din;
    assign if2.en = r_en; assign if2.we = r_we; assign if2.be = r_be; assign if2.addr = r_addr; assign if2.din = r_din;
    assign if3.en = r_en; assign if3.we = r_we; assign if3.be = r_be; assign if3.addr = r_addr; assign if3.din = r_din;
    assign if4.en = r_en; assign if4.we = r_we; assign if4.be = r_be; assign if4.addr = r_addr; assign if4.din = r_din;

    sp_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16),
                .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    sp_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16),
                .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    sp_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16),
                .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    sp_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16),
                .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1))
        u3 (.clk(clk), .rst(rst_b), .bus(if3));
    sp_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12),
                .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u4 (.clk(clk), .rst(rst), .bus(if4));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic en, input logic we, input logic [3:0] be,
                      input logic [3:0] addr, input logic [31:0] din);
        r_en   = en;
        r_we   = we;
        r_be   = be;
        r_addr = addr;
        r_din  = din;
        cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        r_en = 1'b0; r_we = 1'b0; r_be = 4'h0; r_addr = 4'h0; r_din = 32'h0;
        cyc();
        cyc();
        chk("rst_busy0",  32'(if0.busy), 32'd1);
        chk("rst_dout0",  if0.dout, 32'h0);
        chk("rst_dv0",    32'(if0.dout_valid), 32'd0);
        chk("rst_busy3",  32'(if3.busy), 32'd1);
        chk("rst_dv3",    32'(if3.dout_valid), 32'd0);

        // Clear window: busy for 16 cycles, requests during it are ignored.
        rst = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("clr_busy0_%0d", i), 32'(if0.busy), 32'd1);
            chk($sformatf("clr_busy3_%0d", i), 32'(if3.busy), 32'd1);
            r_en = (i < 15); r_we = 1'b0; r_addr = 4'h0;
            cyc();
            chk($sformatf("clr_dv0_%0d", i), 32'(if0.dout_valid), 32'd0);
        end
        chk("clr_done0", 32'(if0.busy), 32'd0);
        chk("clr_done3", 32'(if3.busy), 32'd0);

        for (int a = 0; a < 16; a++) begin
            op(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
            chk($sformatf("zero_rd%0d", a), if0.dout, 32'h0);
            chk($sformatf("zero_dv%0d", a), 32'(if0.dout_valid), 32'd1);
        end
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        // Byte enables
        op(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD);
        op(1'b1, 1'b1, 4'h5, 4'd3, 32'h11223344);
        op(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        chk("be_rd0", if0.dout, 32'hAA22CC44);
        chk("be_dv0", 32'(if0.dout_valid), 32'd1);
        chk("be_rd1", if1.dout, 32'hAA22CC44);
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        // Read-during-write modes
        op(1'b1, 1'b1, 4'hF, 4'd5, 32'h12345678);
        op(1'b1, 1'b1, 4'hC, 4'd5, 32'hFFFF0000);
        chk("rdw_rf_dout", if0.dout, 32'h12345678);
        chk("rdw_rf_dv",   32'(if0.dout_valid), 32'd1);
        chk("rdw_wf_dout", if1.dout, 32'hFFFF5678);
        chk("rdw_wf_dv",   32'(if1.dout_valid), 32'd1);
        chk("rdw_nc_dout", if2.dout, 32'hAA22CC44);
        chk("rdw_nc_dv",   32'(if2.dout_valid), 32'd0);
        op(1'b1, 1'b1, 4'h0, 4'd5, 32'h00000000);
        chk("be0_wf_dout", if1.dout, 32'hFFFF5678);
        op(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        chk("be0_rd", if0.dout, 32'hFFFF5678);
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk("idle_hold", if0.dout, 32'hFFFF5678);
        chk("idle_dv",   32'(if0.dout_valid), 32'd0);

        // Output-register latency and back-to-back reads
        for (int a = 0; a < 8; a++) op(1'b1, 1'b1, 4'hF, 4'(a), 32'(a));
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        for (int j = 0; j < 10; j++) begin
            if (j < 8) op(1'b1, 1'b0, 4'h0, 4'(j), 32'h0);
            else       op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
            chk($sformatf("lat_dv%0d", j), 32'(if3.dout_valid), 32'((j >= 1) && (j <= 8)));
            if ((j >= 1) && (j <= 8))
                chk($sformatf("lat_dout%0d", j), if3.dout, 32'(j - 1));
        end

        // Out-of-range on the 12-word instance
        op(1'b1, 1'b1, 4'hF, 4'd13, 32'hDEADBEEF);
        op(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
        chk("oor_rd", if4.dout, 32'h0);
        chk("oor_dv", 32'(if4.dout_valid), 32'd1);
        for (int a = 0; a < 12; a++) begin
            op(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
            chk($sformatf("oor_keep%0d", a), if4.dout, (a < 8) ? 32'(a) : 32'h0);
        end
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

        // Mid-operation reset with a read in the output stage
        op(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk("pre_rst_dout", if3.dout, 32'd7);
        op(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        rst_b = 1'b1;
        op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        chk("mid_rst_dv",   32'(if3.dout_valid), 32'd0);
        chk("mid_rst_dout", if3.dout, 32'h0);
        chk("mid_rst_busy", 32'(if3.busy), 32'd1);
        rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("reclr_busy%0d", i), 32'(if3.busy), 32'd1);
            chk($sformatf("reclr_dv%0d", i), 32'(if3.dout_valid), 32'd0);
            cyc();
        end
        chk("reclr_done", 32'(if3.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
